alu_pattern_seq: RTL and testbench

ALU_PATTERN_SEQ -- requirements
Module: alu_pattern_seq

---
 rtl/alu_pattern_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_pattern_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pattern_seq.sv
// Pattern-driven ALU tester: loads stimulus/expected/mask vectors, applies them to an
// external ALU one at a time, and tallies masked response mismatches.
module alu_pattern_seq #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [8:0]                   ld_data,
   input  logic                         pat_clr,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [1:0]                   alu_ain,
   output logic [1:0]                   alu_bin,
   output logic                         alu_sel,
   input  logic [1:0]                   alu_zout,
   output logic [$clog2(DEPTH):0]       pat_cnt,
   output logic [$clog2(DEPTH):0]       fail_cnt,
   output logic                         fail_seen,
   output logic [$clog2(DEPTH)-1:0]     first_fail
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] APPLY  = 3'd1;
   localparam logic [2:0] SETTLE = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [8:0]    mem [DEPTH];

   logic [2:0]    state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [SW-1:0] cnt, cnt_n;
   logic [CW-1:0] pat_cnt_n, fail_cnt_n;
   logic          fail_seen_n;
   logic [AW-1:0] first_fail_n;
   logic [1:0]    alu_ain_n, alu_bin_n;
   logic          alu_sel_n;
   logic          done_n, busy_n, ld_ready_n;

   logic          in_idle, has_room, clr_acc, wr_en, miss;
   logic [8:0]    cur;

   assign in_idle  = (state == IDLE);
   assign has_room = (pat_cnt < CW'(DEPTH));
   // pat_clr outranks a load in the same cycle
   assign clr_acc  = in_idle && pat_clr;
   assign wr_en    = in_idle && has_room && ld_valid && !pat_clr;
   assign cur      = mem[idx];
   assign miss     = |((alu_zout ^ cur[3:2]) & cur[1:0]);

   // Pattern memory, intentionally unreset
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[pat_cnt[AW-1:0]] <= ld_data;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      idx_n        = idx;
      cnt_n        = cnt;
      pat_cnt_n    = pat_cnt;
      fail_cnt_n   = fail_cnt;
      fail_seen_n  = fail_seen;
      first_fail_n = first_fail;
      alu_ain_n    = alu_ain;
      alu_bin_n    = alu_bin;
      alu_sel_n    = alu_sel;

      case (state)
         IDLE: begin
            if (clr_acc) begin
               pat_cnt_n = '0;
            end else if (wr_en) begin
               pat_cnt_n = pat_cnt + CW'(1);
            end else if (start) begin
               fail_cnt_n   = '0;
               fail_seen_n  = 1'b0;
               first_fail_n = '0;
               idx_n        = '0;
               state_n      = (pat_cnt == '0) ? DONE : APPLY;
            end
         end
         APPLY: begin
            alu_ain_n = cur[8:7];
            alu_bin_n = cur[6:5];
            alu_sel_n = cur[4];
            cnt_n     = SW'(SETTLE_CYC);
            state_n   = SETTLE;
         end
         SETTLE: begin
            if (cnt == SW'(1)) begin
               state_n = CHECK;
            end else begin
               cnt_n = cnt - SW'(1);
            end
         end
         CHECK: begin
            if (miss) begin
               fail_cnt_n = fail_cnt + CW'(1);
               if (!fail_seen) begin
                  fail_seen_n  = 1'b1;
                  first_fail_n = idx;
               end
            end
            if (CW'(idx) == pat_cnt - CW'(1)) begin
               state_n = DONE;
            end else begin
               idx_n   = idx + AW'(1);
               state_n = APPLY;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      done_n     = (state_n == DONE);
      busy_n     = (state_n != IDLE);
      ld_ready_n = (state_n == IDLE) && (pat_cnt_n < CW'(DEPTH));
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         pat_cnt    <= '0;
         fail_cnt   <= '0;
         fail_seen  <= 1'b0;
         first_fail <= '0;
         alu_ain    <= '0;
         alu_bin    <= '0;
         alu_sel    <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         ld_ready   <= 1'b1;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         pat_cnt    <= pat_cnt_n;
         fail_cnt   <= fail_cnt_n;
         fail_seen  <= fail_seen_n;
         first_fail <= first_fail_n;
         alu_ain    <= alu_ain_n;
         alu_bin    <= alu_bin_n;
         alu_sel    <= alu_sel_n;
         done       <= done_n;
         busy       <= busy_n;
         ld_ready   <= ld_ready_n;
      end
   end

endmodule

// File: tb/tb_alu_pattern_seq.sv
// Directed bench for alu_pattern_seq with a small behavioural ALU and hand-computed results.
module tb_alu_pattern_seq;

   logic       clk = 1'b0;
   logic       rst, ld_valid, ld_ready, pat_clr, start, busy, done;
   logic [8:0] ld_data;
   logic [1:0] alu_ain, alu_bin, alu_zout;
   logic       alu_sel;
   logic [3:0] pat_cnt, fail_cnt;
   logic       fail_seen;
   logic [2:0] first_fail;

   int n_chk  = 0;
   int n_pass = 0;

   logic       use_tbl;
   logic [1:0] tbl1;
   logic [4:0] seen [$];
   logic [4:0] prev;
   int         lat;

   alu_pattern_seq dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .pat_clr(pat_clr), .start(start), .busy(busy), .done(done),
      .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_sel(alu_sel), .alu_zout(alu_zout),
      .pat_cnt(pat_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen), .first_fail(first_fail)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] alu_ref(input logic [1:0] a, input logic [1:0] b, input logic s);
      return s ? 2'(a + b) : (a ^ b);
   endfunction

   // Bench ALU: fixed response table for the three-pattern runs, otherwise alu_ref
   always_comb begin
      alu_zout = 2'b00;
      if (use_tbl) begin
         case ({alu_ain, alu_bin, alu_sel})
            5'b11101: alu_zout = 2'b10;
            5'b01101: alu_zout = tbl1;
            5'b01111: alu_zout = 2'b11;
            default:  alu_zout = 2'b00;
         endcase
      end else begin
         alu_zout = alu_ref(alu_ain, alu_bin, alu_sel);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [8:0] d);
      ld_valid = 1'b1;
      ld_data  = d;
      tick();
      ld_valid = 1'b0;
   endtask

   // Pulse start, count cycles until done; optionally re-pulse start mid-run
   task automatic run(input int restart_at, output int latency);
      seen.delete();
      prev  = {alu_ain, alu_bin, alu_sel};
      start = 1'b1;
      tick();
      start   = 1'b0;
      latency = 1;
      while (done !== 1'b1 && latency < 200) begin
         if ({alu_ain, alu_bin, alu_sel} != prev) begin
            prev = {alu_ain, alu_bin, alu_sel};
            seen.push_back(prev);
         end
         start = (latency == restart_at);
         tick();
         latency++;
      end
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ld_valid = 1'b0; ld_data = '0; pat_clr = 1'b0; start = 1'b0;
      use_tbl = 1'b1; tbl1 = 2'b00;
      tick(); tick();
      rst = 1'b0;

      check("rst_busy",     32'(busy), 32'd0);
      check("rst_done",     32'(done), 32'd0);
      check("rst_pat_cnt",  32'(pat_cnt), 32'd0);
      check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_alu",      32'({alu_ain, alu_bin, alu_sel}), 32'd0);

      // Empty pattern set: straight to DONE
      pat_clr = 1'b1; tick(); pat_clr = 1'b0;
      run(-1, lat);
      check("empty_latency",  32'(lat), 32'd1);
      check("empty_fail_cnt", 32'(fail_cnt), 32'd0);
      tick();
      check("empty_done_1cyc", 32'(done), 32'd0);

      // Three patterns, all passing; start re-pulsed while busy
      load(9'b11_10_1_10_11);
      load(9'b01_10_1_00_11);
      load(9'b01_11_1_01_01);
      check("pat_cnt3", 32'(pat_cnt), 32'd3);
      run(5, lat);
      check("pass_latency",  32'(lat), 32'd13);
      check("pass_fail_cnt", 32'(fail_cnt), 32'd0);
      check("pass_fail_seen", 32'(fail_seen), 32'd0);
      check("stim_count", 32'(seen.size()), 32'd3);
      if (seen.size() == 3) begin
         check("stim0", 32'(seen[0]), 32'b11101);
         check("stim1", 32'(seen[1]), 32'b01101);
         check("stim2", 32'(seen[2]), 32'b01111);
      end
      tick();
      check("no_restart_busy", 32'(busy), 32'd0);
      check("no_restart_done", 32'(done), 32'd0);
      check("alu_hold", 32'({alu_ain, alu_bin, alu_sel}), 32'b01111);

      // Pattern 1 mismatches; pattern 2 differs only in a masked-off bit
      tbl1 = 2'b01;
      run(-1, lat);
      check("fail_latency",   32'(lat), 32'd13);
      check("fail_cnt1",      32'(fail_cnt), 32'd1);
      check("fail_seen1",     32'(fail_seen), 32'd1);
      check("first_fail1",    32'(first_fail), 32'd1);
      tick();

      // start with an accepted load in the same cycle is ignored
      start = 1'b1; ld_valid = 1'b1; ld_data = 9'b00_00_0_00_00;
      tick();
      start = 1'b0; ld_valid = 1'b0;
      check("ld_start_pat_cnt", 32'(pat_cnt), 32'd4);
      check("ld_start_busy",    32'(busy), 32'd0);
      tick();
      check("ld_start_no_done", 32'(done), 32'd0);

      // Fill all 8 entries; last one masks out a wrong expected value
      pat_clr = 1'b1; tick(); pat_clr = 1'b0;
      use_tbl = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [1:0] a, b, e, m;
         logic       s;
         a = 2'(i);
         b = 2'(i >> 1);
         s = i[0];
         e = (i == 7) ? ~alu_ref(a, b, s) : alu_ref(a, b, s);
         m = (i == 7) ? 2'b00 : 2'b11;
         load({a, b, s, e, m});
      end
      check("full_pat_cnt",  32'(pat_cnt), 32'd8);
      check("full_ld_ready", 32'(ld_ready), 32'd0);
      // Would corrupt entry 0 if written
      ld_valid = 1'b1; ld_data = 9'b00_00_0_11_11;
      tick();
      ld_valid = 1'b0;
      check("full_pat_cnt_hold", 32'(pat_cnt), 32'd8);
      run(-1, lat);
      check("full_latency",  32'(lat), 32'd33);
      check("full_fail_cnt", 32'(fail_cnt), 32'd0);
      tick();

      // Reset during SETTLE of pattern 1 aborts the run
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("abort_busy",     32'(busy), 32'd0);
      check("abort_done",     32'(done), 32'd0);
      check("abort_pat_cnt",  32'(pat_cnt), 32'd0);
      check("abort_fail",     32'({fail_cnt, fail_seen, first_fail}), 32'd0);
      check("abort_alu",      32'({alu_ain, alu_bin, alu_sel}), 32'd0);
      check("abort_ld_ready", 32'(ld_ready), 32'd1);
      begin
         int pulses = 0;
         for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            tick();
         end
         check("abort_no_done", 32'(pulses), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
